// File: rtl/instr_encoder.sv
// Program-loader front end: assembles symbolic MIPS requests into 32-bit words and writes them sequentially.
// Optional field checking is enabled by defining INSTR_ENC_FIELD_CHECK_EN.
module instr_encoder #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err_illegal,
  output logic              err_field
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  state_t            state_r;
  state_t            state_next_s;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W:0]   count_r;
  logic              we_r;
  logic [ADDR_W-1:0] waddr_r;
  logic [31:0]       wdata_r;
  logic              err_illegal_r;
  logic              accept_s;
  logic              legal_s;
  logic [31:0]       word_s;

  // Unused fields of each format are dropped here rather than passed through.
  function automatic logic [31:0] encode_word(
    input logic [3:0]  f_op,
    input logic [4:0]  f_rs,
    input logic [4:0]  f_rt,
    input logic [4:0]  f_rd,
    input logic [4:0]  f_shamt,
    input logic [15:0] f_imm,
    input logic [25:0] f_target
  );
    logic [31:0] w;
    case (f_op)
      4'd0:    w = {6'b000000, f_rs, f_rt, f_rd, 5'd0, 6'b100000};
      4'd1:    w = {6'b000000, f_rs, f_rt, f_rd, 5'd0, 6'b100100};
      4'd2:    w = {6'b000000, f_rs, f_rt, f_rd, 5'd0, 6'b100101};
      4'd3:    w = {6'b000000, f_rs, f_rt, f_rd, 5'd0, 6'b101010};
      4'd4:    w = {6'b000000, 5'd0, f_rt, f_rd, f_shamt, 6'b000000};
      4'd5:    w = {6'b000000, 5'd0, f_rt, f_rd, f_shamt, 6'b000010};
      4'd6:    w = {6'b000000, f_rs, f_rt, f_rd, 5'd0, 6'b100010};
      4'd7:    w = {6'b000000, f_rs, 15'd0, 6'b001000};
      4'd8:    w = {6'b001000, f_rs, f_rt, f_imm};
      4'd9:    w = {6'b000100, f_rs, f_rt, f_imm};
      4'd10:   w = {6'b000101, f_rs, f_rt, f_imm};
      4'd11:   w = {6'b100011, f_rs, f_rt, f_imm};
      4'd12:   w = {6'b101011, f_rs, f_rt, f_imm};
      4'd13:   w = {6'b000011, f_target};
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

`ifdef INSTR_ENC_FIELD_CHECK_EN
  function automatic logic field_discarded(
    input logic [3:0] f_op,
    input logic [4:0] f_rs,
    input logic [4:0] f_rt,
    input logic [4:0] f_rd,
    input logic [4:0] f_shamt
  );
    logic bad;
    case (f_op)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd6: bad = (f_shamt != 5'd0);
      4'd4, 4'd5:                   bad = (f_rs != 5'd0);
      4'd7:    bad = (f_rt != 5'd0) || (f_rd != 5'd0) || (f_shamt != 5'd0);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction
`endif

  assign in_ready  = (state_r == ST_LOAD) && !start;
  assign accept_s  = in_valid && in_ready;
  assign legal_s   = (op <= 4'd13);
  assign word_s    = encode_word(op, rs, rt, rd, shamt, imm, target);

  assign mem_we      = we_r;
  assign mem_addr    = waddr_r;
  assign mem_wdata   = wdata_r;
  assign count       = count_r;
  assign full        = (state_r == ST_FULL);
  assign err_illegal = err_illegal_r;

  // Next-state logic; start always returns to LOAD.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_next_s = ST_LOAD;
        else       state_next_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (start)                                          state_next_s = ST_LOAD;
        else if (accept_s && legal_s && addr_r == LAST_ADDR) state_next_s = ST_FULL;
        else                                                state_next_s = ST_LOAD;
      end
      ST_FULL: begin
        if (start) state_next_s = ST_LOAD;
        else       state_next_s = ST_FULL;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State, address/count and write-port registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      addr_r        <= '0;
      count_r       <= '0;
      we_r          <= 1'b0;
      waddr_r       <= '0;
      wdata_r       <= 32'h0000_0000;
      err_illegal_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (start) begin
        // A word already on the write port is replayed at address 0 of the new image.
        we_r          <= we_r;
        waddr_r       <= '0;
        addr_r        <= ADDR_W'(we_r);
        count_r       <= (ADDR_W+1)'(we_r);
        err_illegal_r <= 1'b0;
      end else if (accept_s && legal_s) begin
        we_r    <= 1'b1;
        waddr_r <= addr_r;
        wdata_r <= word_s;
        addr_r  <= addr_r + ADDR_W'(1);
        count_r <= count_r + (ADDR_W+1)'(1);
      end else if (accept_s) begin
        we_r          <= 1'b0;
        err_illegal_r <= 1'b1;
      end else begin
        we_r <= 1'b0;
      end
    end
  end

`ifdef INSTR_ENC_FIELD_CHECK_EN
  logic err_field_r;

  // Sticky flag for legal requests whose discarded fields were nonzero.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_field_r <= 1'b0;
    end else if (start) begin
      err_field_r <= 1'b0;
    end else if (accept_s && legal_s && field_discarded(op, rs, rt, rd, shamt)) begin
      err_field_r <= 1'b1;
    end else begin
      err_field_r <= err_field_r;
    end
  end

  assign err_field = err_field_r;
`else
  assign err_field = 1'b0;
`endif

endmodule
